// File: rtl/alloc_addr_server.sv
// rtl/alloc_addr_server.sv - free-address server: free-list FIFO backed by a bump pointer, with flush handshake
//
// Hands out memory addresses to the memcached pipeline and takes freed ones back.
// Addresses are offered from a single output register. That register is refilled
// from the free-list FIFO first and from a bump pointer second
// (ADDR_BASE + n*ADDR_STRIDE while n < ADDR_LIMIT).
// A flush request clears the free list, the bump pointer and the output register.
// The server then raises flushAck until the pipeline reports flushDone.
//
// Optional feature: define ALLOC_ADDR_SERVER_STATS_EN to add the saturating
// stat_alloc_cnt / stat_free_cnt counters.
//
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   app2alloc_t*          returned (freed) address stream in
//   alloc2app_t*          free address stream out
//   app2alloc_flushReq    flush request (level)
//   alloc2app_flushAck    flush done, waiting for app2alloc_flushDone
//   app2alloc_flushDone   pipeline finished its flush
//   stat_alloc_cnt        alloc2app handshakes since reset/flush (STATS_EN only)
//   stat_free_cnt         app2alloc handshakes since reset/flush (STATS_EN only)

module alloc_addr_server #(
    parameter logic [31:0] ADDR_BASE     = 32'h0000_0000,
    parameter logic [31:0] ADDR_STRIDE   = 32'h0000_0040,
    parameter int unsigned ADDR_LIMIT    = 1024,
    parameter int unsigned FL_DEPTH_LOG2 = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [31:0] app2alloc_tdata,
    input  logic        app2alloc_tvalid,
    output logic        app2alloc_tready,
    output logic [31:0] alloc2app_tdata,
    output logic        alloc2app_tvalid,
    input  logic        alloc2app_tready,
    input  logic        app2alloc_flushReq,
    output logic        alloc2app_flushAck,
    input  logic        app2alloc_flushDone
`ifdef ALLOC_ADDR_SERVER_STATS_EN
    ,
    output logic [31:0] stat_alloc_cnt,
    output logic [31:0] stat_free_cnt
`endif
);

    localparam int unsigned PTR_W    = FL_DEPTH_LOG2;
    localparam int unsigned FL_DEPTH = 1 << FL_DEPTH_LOG2;
    localparam logic [PTR_W:0] FL_FULL = (PTR_W + 1)'(FL_DEPTH);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        FLUSH_WAIT = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic [31:0]    flMem [FL_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0] flCount;
    logic           flEmpty;
    logic           flFull;

    logic [31:0]    bumpCnt;
    logic [31:0]    bumpAddr;
    logic           bumpAvail;

    logic           outValid;
    logic [31:0]    outData;

    logic           runActive;
    logic           flPush;
    logic           flPop;
    logic           consume;
    logic           regLoad;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        nextState = state;
        case (state)
            RUN:        if (app2alloc_flushReq) nextState = FLUSH;
            FLUSH:      nextState = FLUSH_WAIT;
            FLUSH_WAIT: if (app2alloc_flushDone) nextState = RUN;
            default:    nextState = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A pending flush request masks both handshakes so that a transfer in the
    // request cycle is never seen as accepted by either side.
    always_comb begin
        runActive          = (state == RUN) && !app2alloc_flushReq && !ap_rst;
        app2alloc_tready   = runActive && !flFull;
        alloc2app_tvalid   = runActive && outValid;
        alloc2app_tdata    = ap_rst ? 32'h0 : outData;
        alloc2app_flushAck = (state == FLUSH_WAIT) && !ap_rst;
    end

    // ---------------- datapath ----------------
    assign flEmpty   = (flCount == '0);
    assign flFull    = (flCount == FL_FULL);
    assign bumpAvail = (bumpCnt < 32'(ADDR_LIMIT));

    assign flPush  = app2alloc_tready && app2alloc_tvalid;
    assign consume = alloc2app_tvalid && alloc2app_tready;
    // The output register refills when it is empty or is drained this cycle.
    assign regLoad = runActive && (!outValid || consume);
    assign flPop   = regLoad && !flEmpty;

    always_ff @(posedge ap_clk) begin
        if (flPush) begin
            flMem[wrPtr] <= app2alloc_tdata;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst || state == FLUSH) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            flCount  <= '0;
            bumpCnt  <= 32'h0;
            bumpAddr <= ADDR_BASE;
            outValid <= 1'b0;
            outData  <= 32'h0;
        end else begin
            if (flPush) wrPtr <= wrPtr + PTR_W'(1);
            if (flPop)  rdPtr <= rdPtr + PTR_W'(1);

            case ({flPush, flPop})
                2'b10:   flCount <= flCount + (PTR_W + 1)'(1);
                2'b01:   flCount <= flCount - (PTR_W + 1)'(1);
                default: flCount <= flCount;
            endcase

            if (regLoad) begin
                if (!flEmpty) begin
                    outValid <= 1'b1;
                    outData  <= flMem[rdPtr];
                end else if (bumpAvail) begin
                    outValid <= 1'b1;
                    outData  <= bumpAddr;
                    bumpAddr <= bumpAddr + ADDR_STRIDE;
                    bumpCnt  <= bumpCnt + 32'd1;
                end else begin
                    outValid <= 1'b0;
                end
            end
        end
    end

`ifdef ALLOC_ADDR_SERVER_STATS_EN
    // Counters clear on the RUN->FLUSH transition and saturate at all-ones.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || (state == RUN && nextState == FLUSH)) begin
            stat_alloc_cnt <= 32'h0;
            stat_free_cnt  <= 32'h0;
        end else begin
            if (consume && stat_alloc_cnt != 32'hFFFF_FFFF) begin
                stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
            end
            if (flPush && stat_free_cnt != 32'hFFFF_FFFF) begin
                stat_free_cnt <= stat_free_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alloc_addr_server.sv
// tb/tb_alloc_addr_server.sv - scoreboard bench for alloc_addr_server

module tb_alloc_addr_server;

    logic        clk;
    logic        ap_rst;
    logic [31:0] app2alloc_tdata;
    logic        app2alloc_tvalid;
    logic        app2alloc_tready;
    logic [31:0] alloc2app_tdata;
    logic        alloc2app_tvalid;
    logic        alloc2app_tready;
    logic        app2alloc_flushReq;
    logic        alloc2app_flushAck;
    logic        app2alloc_flushDone;
`ifdef ALLOC_ADDR_SERVER_STATS_EN
    logic [31:0] stat_alloc_cnt;
    logic [31:0] stat_free_cnt;
`endif

    int passCnt  = 0;
    int totalCnt = 0;
    logic [31:0] expQ[$];

    alloc_addr_server #(
        .ADDR_BASE    (32'h0000_0000),
        .ADDR_STRIDE  (32'h0000_0040),
        .ADDR_LIMIT   (4),
        .FL_DEPTH_LOG2(2)
    ) dut (
        .ap_clk             (clk),
        .ap_rst             (ap_rst),
        .app2alloc_tdata    (app2alloc_tdata),
        .app2alloc_tvalid   (app2alloc_tvalid),
        .app2alloc_tready   (app2alloc_tready),
        .alloc2app_tdata    (alloc2app_tdata),
        .alloc2app_tvalid   (alloc2app_tvalid),
        .alloc2app_tready   (alloc2app_tready),
        .app2alloc_flushReq (app2alloc_flushReq),
        .alloc2app_flushAck (alloc2app_flushAck),
        .app2alloc_flushDone(app2alloc_flushDone)
`ifdef ALLOC_ADDR_SERVER_STATS_EN
        ,
        .stat_alloc_cnt     (stat_alloc_cnt),
        .stat_free_cnt      (stat_free_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic returnWord(input logic [31:0] w);
        app2alloc_tdata  = w;
        app2alloc_tvalid = 1'b1;
        @(negedge clk);
        check("ret_ready", {31'b0, app2alloc_tready}, 32'd1);
        @(posedge clk);
        #1;
        app2alloc_tvalid = 1'b0;
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard monitor: every output handshake must match the queue head.
    always @(negedge clk) begin
        if (!ap_rst && alloc2app_tvalid && alloc2app_tready) begin
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpected_alloc: got 0x%08h expected none", alloc2app_tdata);
            end else begin
                check("alloc_data", alloc2app_tdata, expQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst              = 1'b1;
        app2alloc_tdata     = 32'h0;
        app2alloc_tvalid    = 1'b0;
        alloc2app_tready    = 1'b0;
        app2alloc_flushReq  = 1'b0;
        app2alloc_flushDone = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", {31'b0, alloc2app_tvalid}, 32'd0);
        check("rst_tdata", alloc2app_tdata, 32'h0);
        check("rst_in_tready", {31'b0, app2alloc_tready}, 32'd0);
        check("rst_flushAck", {31'b0, alloc2app_flushAck}, 32'd0);

        // Bump sequence after reset release
        @(posedge clk);
        #1;
        ap_rst           = 1'b0;
        alloc2app_tready = 1'b1;
        expQ.push_back(32'h00);
        expQ.push_back(32'h40);
        expQ.push_back(32'h80);
        expQ.push_back(32'hC0);
        @(negedge clk);
        check("release_empty", {31'b0, alloc2app_tvalid}, 32'd0);
        step(1);
        drain(20);
        step(3);
        @(negedge clk);
        check("exhausted", {31'b0, alloc2app_tvalid}, 32'd0);
        step(1);

        // Free-list latency: accepted at t, offered at t+2
        expQ.push_back(32'h80);
        returnWord(32'h80);
        @(negedge clk);
        check("lat_t1", {31'b0, alloc2app_tvalid}, 32'd0);
        @(negedge clk);
        check("lat_t2", {31'b0, alloc2app_tvalid}, 32'd1);
        step(1);

        // Fill: one word in the register plus four in the free list
        alloc2app_tready = 1'b0;
        returnWord(32'h200);
        returnWord(32'h100);
        returnWord(32'h140);
        returnWord(32'h180);
        returnWord(32'h1C0);
        @(negedge clk);
        check("fl_full", {31'b0, app2alloc_tready}, 32'd0);
        step(1);
        alloc2app_tready = 1'b1;
        expQ.push_back(32'h200);
        step(1);
        app2alloc_tdata  = 32'h240;
        app2alloc_tvalid = 1'b1;
        expQ.push_back(32'h100);
        @(negedge clk);
        check("ready_after_pop", {31'b0, app2alloc_tready}, 32'd1);
        step(1);
        app2alloc_tvalid = 1'b0;
        alloc2app_tready = 1'b0;
        @(negedge clk);
        check("push_pop_ready", {31'b0, app2alloc_tready}, 32'd1);
        step(1);
        expQ.push_back(32'h140);
        expQ.push_back(32'h180);
        expQ.push_back(32'h1C0);
        expQ.push_back(32'h240);
        alloc2app_tready = 1'b1;
        drain(20);

        // Flush with a word pending in the output register
        alloc2app_tready = 1'b0;
        returnWord(32'h300);
        step(1);
        app2alloc_flushReq = 1'b1;
        step(1);
        app2alloc_flushReq = 1'b0;
        @(negedge clk);
        check("flush_ack", {31'b0, alloc2app_flushAck}, 32'd0);
        check("flush_tvalid", {31'b0, alloc2app_tvalid}, 32'd0);
        check("flush_in_tready", {31'b0, app2alloc_tready}, 32'd0);
        step(1);
        @(negedge clk);
        check("wait_ack", {31'b0, alloc2app_flushAck}, 32'd1);
        check("wait_tvalid", {31'b0, alloc2app_tvalid}, 32'd0);
        check("wait_in_tready", {31'b0, app2alloc_tready}, 32'd0);
        step(3);
        @(negedge clk);
        check("wait_ack_hold", {31'b0, alloc2app_flushAck}, 32'd1);
        step(1);
        app2alloc_flushDone = 1'b1;
        step(1);
        app2alloc_flushDone = 1'b0;
        @(negedge clk);
        check("ack_drop", {31'b0, alloc2app_flushAck}, 32'd0);
        check("run_first_empty", {31'b0, alloc2app_tvalid}, 32'd0);
        step(1);
        @(negedge clk);
        check("flush_first_valid", {31'b0, alloc2app_tvalid}, 32'd1);
        check("flush_first_addr", alloc2app_tdata, 32'h0);
        step(1);

        // Free list has priority over the bump pointer
        expQ.push_back(32'h00);
        returnWord(32'h00);
        expQ.push_back(32'h00);
        expQ.push_back(32'h40);
        expQ.push_back(32'h80);
        expQ.push_back(32'hC0);
        alloc2app_tready = 1'b1;
        drain(20);
        step(3);
        @(negedge clk);
        check("exhausted_again", {31'b0, alloc2app_tvalid}, 32'd0);
        step(1);

        // Reset in mid-transfer
        alloc2app_tready = 1'b0;
        returnWord(32'h500);
        step(1);
        ap_rst = 1'b1;
        step(1);
        ap_rst = 1'b0;
        @(negedge clk);
        check("rst_mid_first", {31'b0, alloc2app_tvalid}, 32'd0);
        step(1);
        @(negedge clk);
        check("rst_mid_second_valid", {31'b0, alloc2app_tvalid}, 32'd1);
        check("rst_mid_second_addr", alloc2app_tdata, 32'h0);
        step(1);

`ifdef ALLOC_ADDR_SERVER_STATS_EN
        expQ.push_back(32'h00);
        expQ.push_back(32'h40);
        expQ.push_back(32'h80);
        alloc2app_tready = 1'b1;
        step(3);
        alloc2app_tready = 1'b0;
        returnWord(32'h40);
        @(negedge clk);
        check("stat_alloc", stat_alloc_cnt, 32'd3);
        check("stat_free", stat_free_cnt, 32'd1);
        step(1);
        app2alloc_flushReq = 1'b1;
        step(1);
        app2alloc_flushReq = 1'b0;
        @(negedge clk);
        check("stat_alloc_flush", stat_alloc_cnt, 32'd0);
        check("stat_free_flush", stat_free_cnt, 32'd0);
        step(1);
        app2alloc_flushDone = 1'b1;
        step(1);
        app2alloc_flushDone = 1'b0;
`endif

        step(2);
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/alloc_addr_server.md
ALLOC_ADDR_SERVER -- requirements
Module: alloc_addr_server

Interface
REQ-001 Parameter ADDR_BASE, 32'h0000_0000, first address handed out by the bump pointer.
REQ-002 Parameter ADDR_STRIDE, 32'h0000_0040, increment between bump addresses.
REQ-003 Parameter ADDR_LIMIT, 1024, number of bump addresses available after reset or flush.
REQ-004 Parameter FL_DEPTH_LOG2, 4, log2 of the free-list FIFO depth.
REQ-005 ap_clk  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-006 ap_rst  in  1  synchronous active-high reset.
REQ-007 app2alloc_tdata  in  32  address returned (freed) by the memcached pipeline.
REQ-008 app2alloc_tvalid  in  1  returned address valid.
REQ-009 app2alloc_tready  out  1  server accepts the returned address.
REQ-010 alloc2app_tdata  out  32  free address offered to the pipeline.
REQ-011 alloc2app_tvalid  out  1  offered address valid.
REQ-012 alloc2app_tready  in  1  pipeline consumes the offered address.
REQ-013 app2alloc_flushReq  in  1  pipeline requests an allocator flush (level).
REQ-014 alloc2app_flushAck  out  1  flush performed, server waiting for done.
REQ-015 app2alloc_flushDone  in  1  pipeline finished its flush.

Function
REQ-016 Transfers occur on a rising ap_clk when tvalid and tready are both high.
REQ-017 States: RUN, FLUSH, FLUSH_WAIT; RUN is entered from reset.
REQ-018 RUN: app2alloc_tready = free-list not full; an accepted word is pushed to the free-list FIFO.
REQ-019 RUN: single output register; it loads when empty or consumed in the same cycle.
REQ-020 Load source priority: free-list head if non-empty, else bump address ADDR_BASE + n*ADDR_STRIDE while n < ADDR_LIMIT, else register stays empty (tvalid low).
REQ-021 Bump arithmetic is 32-bit modulo 2^32; n increments only when a bump address is loaded.
REQ-022 Push and pop of the free list in the same cycle are both honoured; occupancy is unchanged.
REQ-023 Free-list latency: a word accepted at cycle t into an empty free list with an empty output register appears on alloc2app at t+2.
REQ-024 alloc2app_tdata and alloc2app_tvalid remain stable while tvalid=1 and tready=0, except on flush.
REQ-025 RUN and flushReq=1: the next state is FLUSH; any handshake in that cycle is ignored.
REQ-026 FLUSH, one cycle: clear free-list pointers, n, and the output register; drive app2alloc_tready=0 and alloc2app_tvalid=0; next state is FLUSH_WAIT.
REQ-027 FLUSH_WAIT: alloc2app_flushAck=1, both tready/tvalid outputs 0; on flushDone=1 go to RUN with flushAck=0 in the next cycle.
REQ-028 flushAck is 0 in RUN and FLUSH.
REQ-029 After a flush, the first address offered is ADDR_BASE, one cycle after RUN is re-entered.

Reset
REQ-030 When ap_rst=1 at a clock edge: state RUN, n=0, free list empty, output register empty.
REQ-031 Outputs during reset: alloc2app_tvalid=0, alloc2app_tdata=0, app2alloc_tready=0, alloc2app_flushAck=0.
REQ-032 Reset mid-flush or mid-transfer discards all state; the first cycle after release offers no address, and the second cycle offers ADDR_BASE.

Configuration
REQ-033 Macro ALLOC_ADDR_SERVER_STATS_EN defined: add 32-bit outputs stat_alloc_cnt (increments per alloc2app handshake) and stat_free_cnt (increments per app2alloc handshake).
REQ-034 Both counters reset to 0 on ap_rst and on entering FLUSH, and saturate at 32'hFFFF_FFFF.
REQ-035 Macro ALLOC_ADDR_SERVER_STATS_EN undefined: the ports and counters are absent; other behaviour is identical.

Verification (ADDR_BASE=0, ADDR_STRIDE=0x40, ADDR_LIMIT=4, FL_DEPTH_LOG2=2)
REQ-036 Reset release, alloc2app_tready=1 -> addresses 0x00, 0x40, 0x80, 0xC0 on consecutive cycles, then tvalid=0 permanently.
REQ-037 Exhausted, return 0x80 at cycle t -> alloc2app_tvalid=1 with tdata=0x80 at t+2.
REQ-038 After 0x00 is consumed, return 0x00 -> next offered address is 0x00 (free list before bump), then 0x40.
REQ-039 tready=0 on the output, four returns 0x100..0x1C0 -> app2alloc_tready falls after the 4th; simultaneous push/pop keeps tready high.
REQ-040 flushReq pulse mid-stream -> FLUSH one cycle, flushAck high until flushDone, tready outputs 0; then the first address is 0x00.
REQ-041 ALLOC_ADDR_SERVER_STATS_EN build, 3 allocs + 1 free, then flush -> counters 3/1, then 0/0.
